// File: rtl/memory_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : memory_key_ctrl
//  Description : Front-panel input stage for the array memory. Synchronises
//                and debounces three push-buttons and turns them into
//                data/address/rw commands with a one-cycle ensure strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_key_ctrl #(
   parameter int WIDTH           = 4,
   parameter int ADDR_BITS       = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_INC        = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     sw_data,
   input  logic                 key_ok,
   input  logic                 key_next,
   input  logic                 key_mode,
   output logic [WIDTH-1:0]     data_in,
   output logic [ADDR_BITS-1:0] address,
   output logic                 rw,
   output logic                 ensure
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int NKEYS = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LATCH    = 2'd1,
      STROBE   = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // Key index 0 = ok, 1 = next, 2 = mode
   logic [NKEYS-1:0] raw_keys;
   logic [NKEYS-1:0] key_level;
   logic [NKEYS-1:0] press;

   assign raw_keys = {key_mode, key_next, key_ok};

   genvar k;
   generate
      for (k = 0; k < NKEYS; k++) begin : g_key
         logic             s1;
         logic             s2;
         logic             stable;
         logic             stable_q;
         logic [CNT_W-1:0] cnt;

         // Synchronise the raw key, then accept a new level only after it has
         // been seen unchanged for DEBOUNCE_CYCLES consecutive samples.
         always_ff @(posedge clock) begin
            if (reset) begin
               s1       <= 1'b0;
               s2       <= 1'b0;
               stable   <= 1'b0;
               stable_q <= 1'b0;
               cnt      <= '0;
            end else begin
               s1       <= raw_keys[k];
               s2       <= s1;
               stable_q <= stable;
               if (s2 == stable) begin
                  cnt <= '0;
               end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable <= s2;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end

         assign key_level[k] = stable;
         assign press[k]     = stable & ~stable_q;
      end
   endgenerate

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     data_nxt;
   logic [ADDR_BITS-1:0] address_nxt;
   logic                 rw_nxt;

   // Command state register and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         data_in <= '0;
         address <= '0;
         rw      <= 1'b1;
      end else begin
         state   <= state_nxt;
         data_in <= data_nxt;
         address <= address_nxt;
         rw      <= rw_nxt;
      end
   end

   // Next-state and next-output decode; ok outranks next, next outranks mode
   always_comb begin
      state_nxt   = state;
      data_nxt    = data_in;
      address_nxt = address;
      rw_nxt      = rw;
      case (state)
         IDLE: begin
            if (press[0]) begin
               state_nxt = LATCH;
            end else if (press[1]) begin
               address_nxt = address + ADDR_BITS'(1);
            end else if (press[2]) begin
               rw_nxt = ~rw;
            end
         end
         LATCH: begin
            data_nxt  = sw_data;
            state_nxt = STROBE;
         end
         STROBE: begin
            if (!rw && (AUTO_INC != 0)) begin
               address_nxt = address + ADDR_BITS'(1);
            end
            state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (!key_level[0]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe comes straight from the state register, one cycle per command
   assign ensure = (state == STROBE);

endmodule
`default_nettype wire

// File: tb/tb_memory_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_key_ctrl
//  Description : Self-checking bench for memory_key_ctrl (DEBOUNCE_CYCLES=4).
//                Directed table of key presses plus hand-written latency,
//                bounce and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_key_ctrl;

   localparam int D = 4;

   logic       clock;
   logic       reset;
   logic [3:0] sw_data;
   logic       key_ok;
   logic       key_next;
   logic       key_mode;
   logic [3:0] data_in;
   logic [2:0] address;
   logic       rw;
   logic       ensure;

   int checks = 0;
   int errors = 0;

   memory_key_ctrl #(
      .WIDTH(4), .ADDR_BITS(3), .DEBOUNCE_CYCLES(D), .AUTO_INC(1)
   ) dut (
      .clock(clock), .reset(reset), .sw_data(sw_data),
      .key_ok(key_ok), .key_next(key_next), .key_mode(key_mode),
      .data_in(data_in), .address(address), .rw(rw), .ensure(ensure)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       ok;
      logic       nxt;
      logic       mode;
      logic [3:0] sw;
      int         pulses;
      int         saddr;
      int         sdata;
      int         addr;
      int         rwv;
      int         data;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // Press the given keys for 20 cycles, release, and watch 20 more cycles.
   task automatic press_seq(input logic ok, input logic nx, input logic md,
                            input logic [3:0] sw, output int pulses,
                            output int saddr, output int sdata);
      logic prev;
      pulses = 0; saddr = -1; sdata = -1; prev = 1'b0;
      @(negedge clock);
      sw_data = sw; key_ok = ok; key_next = nx; key_mode = md;
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            key_ok = 1'b0; key_next = 1'b0; key_mode = 1'b0;
         end
         @(negedge clock);
         if (prev) check("ensure_consecutive", int'(ensure), 0);
         if (ensure) begin
            pulses++;
            saddr = int'(address);
            sdata = int'(data_in);
         end
         prev = ensure;
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int p, sa, sd, seen;
      reset = 1'b1; sw_data = 4'd0; key_ok = 1'b0; key_next = 1'b0; key_mode = 1'b0;

      //         ok nx md sw     pl sa sd  ad rw data
      vecs[0]  = '{1, 0, 0, 4'd4,  1, 0, 4,  1, 0, 4};
      vecs[1]  = '{1, 0, 0, 4'd9,  1, 1, 9,  2, 0, 9};
      vecs[2]  = '{0, 1, 0, 4'd0,  0, 0, 0,  3, 0, 9};
      vecs[3]  = '{0, 0, 1, 4'd0,  0, 0, 0,  3, 1, 9};
      vecs[4]  = '{1, 0, 0, 4'd5,  1, 3, 5,  3, 1, 5};
      vecs[5]  = '{1, 1, 0, 4'd6,  1, 3, 6,  3, 1, 6};
      vecs[6]  = '{0, 1, 0, 4'd0,  0, 0, 0,  4, 1, 6};
      vecs[7]  = '{0, 1, 1, 4'd0,  0, 0, 0,  5, 1, 6};
      vecs[8]  = '{0, 0, 1, 4'd0,  0, 0, 0,  5, 0, 6};
      vecs[9]  = '{1, 0, 1, 4'd2,  1, 5, 2,  6, 0, 2};
      vecs[10] = '{1, 0, 0, 4'd12, 1, 6, 12, 7, 0, 12};
      vecs[11] = '{0, 0, 1, 4'd0,  0, 0, 0,  7, 1, 12};
      vecs[12] = '{0, 1, 0, 4'd0,  0, 0, 0,  0, 1, 12};
      vecs[13] = '{1, 0, 0, 4'd15, 1, 0, 15, 0, 1, 15};

      // Reset held 3 cycles, then released
      idle_cycles(3);
      reset = 1'b0;
      @(negedge clock);
      check("reset_data", int'(data_in), 0);
      check("reset_addr", int'(address), 0);
      check("reset_rw", int'(rw), 1);
      check("reset_ensure", int'(ensure), 0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (ensure) seen++;
      end
      check("idle_no_strobe", seen, 0);

      // Bouncing mode key: 2-cycle pulses shorter than the debounce window
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         key_mode = ((i / 2) % 2 == 0);
         @(negedge clock);
         if (ensure) seen++;
      end
      key_mode = 1'b0;
      idle_cycles(20);
      check("bounce_rw", int'(rw), 1);
      check("bounce_no_strobe", seen, 0);

      // Clean mode press held 100 cycles: rw toggles exactly at edge 3+D
      key_mode = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         check("mode_latency_rw", int'(rw), (k >= 3 + D) ? 0 : 1);
      end
      key_mode = 1'b0;
      idle_cycles(20);
      check("mode_after_release_rw", int'(rw), 0);

      // Write command latency: ensure only at edge 4+D with latched data
      sw_data = 4'd4;
      key_ok  = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         check("ok_latency_ensure", int'(ensure), (k == 4 + D) ? 1 : 0);
         if (k == 4 + D) begin
            check("ok_strobe_addr", int'(address), 0);
            check("ok_strobe_data", int'(data_in), 4);
         end
      end
      key_ok = 1'b0;
      idle_cycles(20);
      check("ok_autoinc_addr", int'(address), 1);

      // Seven more writes: addresses 1..7 then wrap to 0
      for (int i = 1; i < 8; i++) begin
         press_seq(1'b1, 1'b0, 1'b0, 4'(i), p, sa, sd);
         check("wrap_pulses", p, 1);
         check("wrap_strobe_addr", sa, i);
         check("wrap_strobe_data", sd, i);
      end
      check("wrap_addr", int'(address), 0);

      // Table of directed presses
      for (int v = 0; v < 14; v++) begin
         press_seq(vecs[v].ok, vecs[v].nxt, vecs[v].mode, vecs[v].sw, p, sa, sd);
         check($sformatf("vec%0d_pulses", v), p, vecs[v].pulses);
         if (vecs[v].pulses > 0) begin
            check($sformatf("vec%0d_strobe_addr", v), sa, vecs[v].saddr);
            check($sformatf("vec%0d_strobe_data", v), sd, vecs[v].sdata);
         end
         check($sformatf("vec%0d_addr", v), int'(address), vecs[v].addr);
         check($sformatf("vec%0d_rw", v), int'(rw), vecs[v].rwv);
         check($sformatf("vec%0d_data", v), int'(data_in), vecs[v].data);
      end

      // Reset during STROBE aborts the command
      press_seq(1'b0, 1'b1, 1'b0, 4'd0, p, sa, sd);
      check("pre_abort_addr", int'(address), 1);
      sw_data = 4'd3;
      key_ok  = 1'b1;
      seen = 0;
      for (int i = 0; i < 30 && seen == 0; i++) begin
         @(negedge clock);
         if (ensure) seen = 1;
      end
      check("abort_strobe_found", seen, 1);
      reset  = 1'b1;
      key_ok = 1'b0;
      @(negedge clock);
      check("abort_ensure", int'(ensure), 0);
      check("abort_addr", int'(address), 0);
      check("abort_rw", int'(rw), 1);
      check("abort_data", int'(data_in), 0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (ensure) seen++;
      end
      check("abort_no_strobe", seen, 0);
      check("abort_addr_held", int'(address), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
